skintone_config_responder: RTL
==============================

# skintone_config_responder

Accelerator-side responder for the config and opcode channels driven by `io_interface`. It decodes `config_wrreq`/`config_rdreq` into a small register bank and returns `config_wrack`/`config_rdack`/`config_dataout`. It also accepts opcodes on `opcode`/`opcode_valid` with `opcode_accept`, and maintains the run state and the `status` word. It sits inside `skintone_v1_00_a_datapath` and feeds configuration and run-control signals to the pixel pipeline.

## Interface
- C_CONFIG_ADDRESS_WIDTH, 36, config address width
- C_CONFIG_DATA_WIDTH, 128, config data width
- C_OPCODE_WIDTH, 16, opcode width
- C_STATUS_WIDTH, 36, status width (fixed layout below)
- C_ID, 128'h5348_494E_0001, read-only ID returned at register 0

One clock; reset is synchronous and active-high.

- clk  in  1  sole clock, all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- config_address  in  36  word index; register = address[2:0], address[35:3] must be 0
- config_datain  in  128  write data
- config_wrreq  in  1  write request level, held until wrack seen
- config_rdreq  in  1  read request level, held until rdack seen
- config_wrack  out  1  one-cycle write acknowledge
- config_rdack  out  1  one-cycle read acknowledge
- config_dataout  out  128  read data, valid with rdack, held until next read
- opcode  in  16  command
- opcode_valid  in  1  command request level, held until accept
- opcode_accept  out  1  one-cycle accept pulse
- pixel_beat  in  1  datapath consumed one input beat
- frame_done  in  1  datapath finished current job
- cfg_thresh  out  128  register 1
- cfg_scale  out  128  register 2
- cfg_misc  out  128  register 3
- run  out  1  engine running level
- start_pulse  out  1  one-cycle pulse on START accept
- status  out  36  status word

## Operation
- Register map: 0 = C_ID (RO); 1–3 = RW; 4–6 = RO 0; 7 = RO {92'b0, status}. Writes to RO registers are acked and have no effect.
- Out-of-range address (address[35:3] ≠ 0): the access is acked. A read returns 0; a write is dropped. Either sets status[34] (sticky).
- Config FSM states: C_IDLE, C_ACK.
  - In C_IDLE with wrreq: perform the write at edge N, assert wrack during cycle N+1, move to C_ACK.
  - In C_IDLE with rdreq and no wrreq: at edge N, load dataout and assert rdack during cycle N+1, move to C_ACK.
  - C_ACK ignores both requests and returns to C_IDLE at the next edge.
  - Peak rate is one transaction per 2 cycles.
- Simultaneous wrreq and rdreq: the write is serviced first. The read remains pending and is serviced in the next C_IDLE.
- Opcode FSM states: O_IDLE, O_ACK, with the same two-cycle pattern. accept is asserted the cycle after valid is sampled in O_IDLE.
  - 0x0001 START: run←1, start_pulse=1 (same cycle as accept), beat counter←0, status[35]←0.
  - 0x0002 STOP: run←0.
  - 0x0003 CLEAR: beat counter←0 and status[33:35]←0; run is unchanged.
  - Any other opcode: accepted, no action, status[33]←1.
- Run engine:
  - While run=1, each pixel_beat increments a 32-bit counter, which wraps from 0xFFFFFFFF to 0.
  - frame_done while run=1 sets run←0 and status[35]←1.
  - pixel_beat and frame_done are ignored while run=0.
- Same-edge priority: a START/CLEAR accept takes priority over a pixel_beat counter increment. frame_done and STOP in the same edge both clear run.
- status layout: [31:0] beat counter, [32] run, [33] illegal opcode (sticky), [34] bad address (sticky), [35] done (sticky).

## Timing
- Reset values: wrack=rdack=accept=start_pulse=0; dataout=0; cfg_*=0; run=0; status=0; both FSMs in IDLE.
- Write-to-cfg_* latency is 1 edge: the new value is visible in the same cycle as wrack.
- A register-7 read returns status as sampled at the request edge.
- All outputs are registered; there is no combinational input-to-output path.
- rst asserted mid-transaction drops the pending ack. All state returns to reset values at that edge.

## Test plan
- Reset, then read address 0 → rdack 2 cycles after rdreq, dataout = C_ID; wrack, accept and status stay 0.
- Write 0xDEAD_BEEF to address 2, then read it back → cfg_scale = 0xDEADBEEF in the wrack cycle; readback matches; cfg_thresh and cfg_misc unchanged.
- wrreq (address 1, data 0x11) and rdreq (address 1) raised in the same cycle → wrack first, rdack 2 cycles later with dataout = 0x11.
- Opcode 0x0001, then 5 pixel_beat, then frame_done, then 3 pixel_beat → status[31:0] = 5, run = 0, status[35] = 1; start_pulse is exactly one cycle.
- Opcode 0x0007, then a write to address 0x8 → both acked; status[33] = 1, status[34] = 1; register 0 still reads C_ID. Opcode 0x0003 → status[35:33] = 0.
- Assert rst one cycle after wrreq (before wrack) → no wrack; cfg_* = 0; a following read of address 1 returns 0.

Source files
------------

// File: rtl/skintone_config_responder.sv
// skintone_config_responder
//
// Accelerator-side responder for the config and opcode channels coming from
// io_interface. Config accesses hit a small register bank (ID, three RW
// configuration words, a status mirror). Opcodes control a run engine that
// counts pixel beats until the datapath reports frame completion.
//
// Ports:
//   clk, rst            sole clock; synchronous active-high reset
//   config_address      word index, register = address[2:0], upper bits must be 0
//   config_datain       write data
//   config_wrreq/rdreq  request levels, held by the master until acked
//   config_wrack/rdack  one-cycle acknowledges
//   config_dataout      read data, valid with rdack and held until the next read
//   opcode/opcode_valid command and its request level
//   opcode_accept       one-cycle accept pulse
//   pixel_beat          datapath consumed one input beat
//   frame_done          datapath finished the current job
//   cfg_thresh/scale/misc  registers 1..3
//   run                 engine running level
//   start_pulse         one-cycle pulse coincident with a START accept
//   status              {done, bad_addr, illegal_op, run, beat_count[31:0]}
module skintone_config_responder #(
  parameter int C_CONFIG_ADDRESS_WIDTH = 36,
  parameter int C_CONFIG_DATA_WIDTH    = 128,
  parameter int C_OPCODE_WIDTH         = 16,
  parameter int C_STATUS_WIDTH         = 36,
  parameter logic [C_CONFIG_DATA_WIDTH-1:0] C_ID = 128'h5348_494E_0001
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [C_CONFIG_ADDRESS_WIDTH-1:0] config_address,
  input  logic [C_CONFIG_DATA_WIDTH-1:0]    config_datain,
  input  logic                              config_wrreq,
  input  logic                              config_rdreq,
  output logic                              config_wrack,
  output logic                              config_rdack,
  output logic [C_CONFIG_DATA_WIDTH-1:0]    config_dataout,
  input  logic [C_OPCODE_WIDTH-1:0]         opcode,
  input  logic                              opcode_valid,
  output logic                              opcode_accept,
  input  logic                              pixel_beat,
  input  logic                              frame_done,
  output logic [C_CONFIG_DATA_WIDTH-1:0]    cfg_thresh,
  output logic [C_CONFIG_DATA_WIDTH-1:0]    cfg_scale,
  output logic [C_CONFIG_DATA_WIDTH-1:0]    cfg_misc,
  output logic                              run,
  output logic                              start_pulse,
  output logic [C_STATUS_WIDTH-1:0]         status
);

  localparam logic [C_OPCODE_WIDTH-1:0] OP_START = C_OPCODE_WIDTH'(1);
  localparam logic [C_OPCODE_WIDTH-1:0] OP_STOP  = C_OPCODE_WIDTH'(2);
  localparam logic [C_OPCODE_WIDTH-1:0] OP_CLEAR = C_OPCODE_WIDTH'(3);

  typedef enum logic { C_IDLE, C_ACK } cfg_state_t;
  typedef enum logic { O_IDLE, O_ACK } op_state_t;

  cfg_state_t cfg_state_reg, cfg_state_next;
  op_state_t  op_state_reg,  op_state_next;

  // Registered outputs and their next values
  logic                           wrack_reg, wrack_next;
  logic                           rdack_reg, rdack_next;
  logic [C_CONFIG_DATA_WIDTH-1:0] dataout_reg, dataout_next;
  logic                           accept_reg, accept_next;
  logic                           start_pulse_reg, start_pulse_next;

  // Register bank 1..3 (index 0 unused; register 0 is the constant ID)
  logic [C_CONFIG_DATA_WIDTH-1:0] cfg_bank_reg [4];
  logic [3:1]                     cfg_we;

  // Run engine / status fields
  logic [31:0] beat_reg, beat_next;
  logic        run_reg, run_next;
  logic        illegal_reg, illegal_next;
  logic        bad_addr_reg, bad_addr_next;
  logic        done_reg, done_next;

  logic [C_STATUS_WIDTH-1:0]      status_word;
  logic [2:0]                     cfg_sel;
  logic                           addr_bad;
  logic                           cfg_wr_fire;
  logic                           cfg_rd_fire;
  logic                           op_fire;
  logic [C_CONFIG_DATA_WIDTH-1:0] rd_mux;

  assign status_word = {done_reg, bad_addr_reg, illegal_reg, run_reg, beat_reg};
  assign cfg_sel     = config_address[2:0];
  assign addr_bad    = |config_address[C_CONFIG_ADDRESS_WIDTH-1:3];

  // A request is only taken in IDLE; write wins when both are raised, and
  // the read stays pending on the master side until the next IDLE.
  assign cfg_wr_fire = (cfg_state_reg == C_IDLE) && config_wrreq;
  assign cfg_rd_fire = (cfg_state_reg == C_IDLE) && !config_wrreq && config_rdreq;
  assign op_fire     = (op_state_reg == O_IDLE) && opcode_valid;

  // Per-register write enables; out-of-range writes never reach the bank
  for (genvar gi = 1; gi <= 3; gi++) begin : g_cfg_we
    assign cfg_we[gi] = cfg_wr_fire && !addr_bad && (cfg_sel == 3'(gi));
  end

  // ---------------------------------------------------------------------
  // State and output registers
  // ---------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      cfg_state_reg   <= C_IDLE;
      op_state_reg    <= O_IDLE;
      wrack_reg       <= 1'b0;
      rdack_reg       <= 1'b0;
      dataout_reg     <= '0;
      accept_reg      <= 1'b0;
      start_pulse_reg <= 1'b0;
      beat_reg        <= '0;
      run_reg         <= 1'b0;
      illegal_reg     <= 1'b0;
      bad_addr_reg    <= 1'b0;
      done_reg        <= 1'b0;
    end else begin
      cfg_state_reg   <= cfg_state_next;
      op_state_reg    <= op_state_next;
      wrack_reg       <= wrack_next;
      rdack_reg       <= rdack_next;
      dataout_reg     <= dataout_next;
      accept_reg      <= accept_next;
      start_pulse_reg <= start_pulse_next;
      beat_reg        <= beat_next;
      run_reg         <= run_next;
      illegal_reg     <= illegal_next;
      bad_addr_reg    <= bad_addr_next;
      done_reg        <= done_next;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 4; i++) cfg_bank_reg[i] <= '0;
    end else begin
      for (int i = 1; i < 4; i++) begin
        if (cfg_we[i]) cfg_bank_reg[i] <= config_datain;
      end
    end
  end

  // ---------------------------------------------------------------------
  // Next-state logic for both handshake FSMs
  // ---------------------------------------------------------------------
  always_comb begin
    cfg_state_next = cfg_state_reg;
    case (cfg_state_reg)
      C_IDLE:  if (cfg_wr_fire || cfg_rd_fire) cfg_state_next = C_ACK;
      C_ACK:   cfg_state_next = C_IDLE;
      default: cfg_state_next = C_IDLE;
    endcase
  end

  always_comb begin
    op_state_next = op_state_reg;
    case (op_state_reg)
      O_IDLE:  if (op_fire) op_state_next = O_ACK;
      O_ACK:   op_state_next = O_IDLE;
      default: op_state_next = O_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------
  // Output / datapath next values
  // ---------------------------------------------------------------------
  always_comb begin
    rd_mux = '0;
    if (!addr_bad) begin
      case (cfg_sel)
        3'd0:    rd_mux = C_ID;
        3'd1:    rd_mux = cfg_bank_reg[1];
        3'd2:    rd_mux = cfg_bank_reg[2];
        3'd3:    rd_mux = cfg_bank_reg[3];
        3'd7:    rd_mux = {{(C_CONFIG_DATA_WIDTH-C_STATUS_WIDTH){1'b0}}, status_word};
        default: rd_mux = '0;
      endcase
    end
  end

  always_comb begin
    wrack_next   = cfg_wr_fire;
    rdack_next   = cfg_rd_fire;
    dataout_next = dataout_reg;
    if (cfg_rd_fire) dataout_next = rd_mux;
  end

  // Run engine. Opcode effects are applied after the beat/done updates so
  // that a START or CLEAR accept overrides a same-edge increment; STOP and
  // frame_done both just clear run, so their order does not matter.
  always_comb begin
    beat_next        = beat_reg;
    run_next         = run_reg;
    illegal_next     = illegal_reg;
    bad_addr_next    = bad_addr_reg;
    done_next        = done_reg;
    accept_next      = op_fire;
    start_pulse_next = 1'b0;

    if (run_reg && pixel_beat) beat_next = beat_reg + 32'd1;
    if (run_reg && frame_done) begin
      run_next  = 1'b0;
      done_next = 1'b1;
    end

    if (op_fire) begin
      case (opcode)
        OP_START: begin
          run_next         = 1'b1;
          beat_next        = '0;
          done_next        = 1'b0;
          start_pulse_next = 1'b1;
        end
        OP_STOP: run_next = 1'b0;
        OP_CLEAR: begin
          beat_next     = '0;
          illegal_next  = 1'b0;
          bad_addr_next = 1'b0;
          done_next     = 1'b0;
        end
        default: illegal_next = 1'b1;
      endcase
    end

    // A bad access in the same edge as CLEAR still leaves its mark
    if ((cfg_wr_fire || cfg_rd_fire) && addr_bad) bad_addr_next = 1'b1;
  end

  assign config_wrack   = wrack_reg;
  assign config_rdack   = rdack_reg;
  assign config_dataout = dataout_reg;
  assign opcode_accept  = accept_reg;
  assign start_pulse    = start_pulse_reg;
  assign cfg_thresh     = cfg_bank_reg[1];
  assign cfg_scale      = cfg_bank_reg[2];
  assign cfg_misc       = cfg_bank_reg[3];
  assign run            = run_reg;
  assign status         = status_word;

endmodule
